maxpool_unit: RTL and testbench
===============================

Name: maxpool_unit

Overview:
- Streaming 2x2, stride-2 max-pool stage placed directly downstream of conv_unit.
- Consumes the post-ReLU conv output stream (unsigned N-bit, raster order, one pixel per valid beat) and emits one pooled pixel per 2x2 window.
- Holds one half-row line buffer of partial maxima, so no full feature-map storage is needed.
- Output feeds the next conv_unit or the flatten/FC stage.

Parameters:
- N, 8, pixel bit width (unsigned, post-ReLU).
- IN_SIZE, 4, input feature-map width = height (conv output size); may be odd.
- OUT_SIZE, IN_SIZE/2 (derived, floor), pooled map width = height; not overridable.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous frame abort; priority over din_vld.
- din_vld  input  1  input pixel valid; may have arbitrary gaps.
- din  input  N  input pixel, unsigned.
- pool_dout  output  N  pooled pixel (registered).
- pool_dout_vld  output  1  one-cycle pulse per pooled pixel.
- pool_dout_end  output  1  one-cycle pulse marking frame completion.

Behaviour:
- Reset (rst_n=0, async): pool_dout=0, pool_dout_vld=0, pool_dout_end=0; col=row=0; state=IDLE; line buffer contents don't-care.
- Counters: col 0..IN_SIZE-1 and row 0..IN_SIZE-1 advance only on accepted beats (din_vld=1, clr=0). col wraps to 0 and increments row. At row=col=IN_SIZE-1 both wrap to 0.
- State machine:
  - IDLE: first beat goes to TOP.
  - TOP: even row.
  - BOT: odd row.
  - DROP: trailing row when IN_SIZE is odd.
  - Transitions occur on the row wrap: TOP->BOT; BOT->TOP if row+1 < 2*OUT_SIZE, else DROP (odd IN_SIZE) or IDLE (frame done); DROP->IDLE.
- Horizontal register h (N bits): loaded with din on an even col. Odd IN_SIZE: the last column (col=IN_SIZE-1) is ignored in every row.
- TOP, odd col: lbuf[col>>1] <= max(h, din).
- BOT, odd col: pool_dout <= max(lbuf[col>>1], h, din) and pool_dout_vld=1 on the next edge. Latency is 1 cycle from the window's bottom-right beat.
- DROP: beats are accepted and counted, but nothing is written and nothing is output.
- Comparisons are unsigned. On ties the result is the shared value. No arithmetic widening is required.
- pool_dout holds its last value when pool_dout_vld=0.
- pool_dout_end: pulses 1 cycle after the final frame beat (row=col=IN_SIZE-1) is accepted.
  - Even IN_SIZE: coincides with the last pool_dout_vld.
  - Odd IN_SIZE: occurs after the last output, as a separate pulse.
- Back-to-back frames: the first beat of the next frame may arrive in the cycle right after the final beat; no bubble is required.
- Gaps: with din_vld=0, state, counters, h and lbuf hold.
- clr=1: next edge forces col=row=0, state=IDLE, pool_dout_vld=0, pool_dout_end=0. A din beat in the same cycle is dropped.
- Reset mid-frame: identical effect to clr, but asynchronous. The partial frame is discarded.
- Exactly OUT_SIZE*OUT_SIZE valid pulses per complete frame.

Decomposition:
- Shared package nn_pkg:
  - state encodings MP_IDLE/MP_TOP/MP_BOT/MP_DROP (2 bits);
  - constant POOL_SIZE=2;
  - max2 function (unsigned compare, width N).
- Sub-module pool_line_buf: OUT_SIZE x N register array, one write port and one async read port, both indexed by col>>1. Flops only, no reset needed on data.

Test Plan:
- IN_SIZE=4, din=1..16 row-major, contiguous -> pool_dout 6,8,14,16.
  - Valid 1 cycle after beats 6, 8, 14, 16.
  - pool_dout_end together with 16.
- Same stimulus with din_vld deasserted for 3 cycles between every beat -> identical values and order. Each valid is exactly 1 cycle after its triggering beat.
- IN_SIZE=5, din=1..25 -> 7,9,17,19.
  - Beats at col 4 and all of row 4 produce no output.
  - pool_dout_end 1 cycle after beat 25; exactly 4 valids.
- IN_SIZE=4, two frames back-to-back (1..16, then all 255) -> 6,8,14,16,255,255,255,255. Two end pulses, no dropped beats.
- IN_SIZE=4: clr after beat 7 (same cycle as a beat), then a full frame 16..1 -> no output from the aborted frame; outputs 16,14,8,6.
- IN_SIZE=4: rst_n low asynchronously mid-cycle after beat 10 -> outputs go to 0 immediately. After release, frame 1..16 gives 6,8,14,16.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the small CNN datapath blocks.
// Max-pool state encoding, pooling window size and an unsigned max helper.
// Pure declarations; no clocked logic lives here.
package nn_pkg;

  typedef enum logic [1:0] {
    MP_IDLE = 2'd0,
    MP_TOP  = 2'd1,
    MP_BOT  = 2'd2,
    MP_DROP = 2'd3
  } mp_state_t;

  localparam int POOL_SIZE = 2;

  // Widest pixel the helper handles; callers zero-extend in and truncate out.
  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] max2(input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row store of partial maxima from the top row of each pooling window.
// Write lands on the clock edge; read is combinational from the flops.
// No flow control: the parent decides when a write happens.
module pool_line_buf #(
  parameter int N     = 8,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [N-1:0]  wr_dat,
  input  logic [AW-1:0] rd_idx,
  output logic [N-1:0]  rd_dat
);

  logic [N-1:0] mem [DEPTH];

  // Data-only storage: contents are meaningless until the top row writes them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_dat;
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/maxpool_unit.sv
// Streaming 2x2 stride-2 max pool over a raster-order post-ReLU pixel stream.
// Latency: pooled pixel is valid 1 cycle after the window's bottom-right beat.
// No backpressure: every din_vld beat is consumed; gaps simply hold all state.
module maxpool_unit
  import nn_pkg::*;
#(
  parameter int N       = 8,
  parameter int IN_SIZE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         din_vld,
  input  logic [N-1:0] din,
  output logic [N-1:0] pool_dout,
  output logic         pool_dout_vld,
  output logic         pool_dout_end
);

  localparam int OUT_SIZE = IN_SIZE / POOL_SIZE;
  localparam int CW       = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int AW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam bit ODD_SIZE = (IN_SIZE % 2) == 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(IN_SIZE - 1);
  localparam logic [CW-1:0] LAST_BOT = CW'(2 * OUT_SIZE - 1);

  mp_state_t     state;
  mp_state_t     cur;
  mp_state_t     wrap_state;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [CW-1:0] col_half;
  logic [N-1:0]  h;
  logic [N-1:0]  lbuf_rd;
  logic [N-1:0]  top_max;
  logic [N-1:0]  win_max;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          col_used;
  logic          lbuf_we;

  assign accept   = din_vld && !clr;
  assign col_last = (col == LAST_IDX);
  assign row_last = (row == LAST_IDX);
  // With an odd width the trailing column never belongs to a window.
  assign col_used = !ODD_SIZE || !col_last;
  // The first beat of a frame is already a top-row pixel.
  assign cur      = (state == MP_IDLE) ? MP_TOP : state;
  assign col_half = col >> 1;

  assign top_max  = N'(max2(MAX_W'(h), MAX_W'(din)));
  assign win_max  = N'(max2(MAX_W'(lbuf_rd), MAX_W'(top_max)));
  assign lbuf_we  = accept && (cur == MP_TOP) && col[0] && col_used;

  // Row-type sequencing applied when a row's last beat is accepted.
  always_comb begin
    wrap_state = MP_IDLE;
    case (cur)
      MP_TOP:  wrap_state = MP_BOT;
      MP_BOT:  wrap_state = (row != LAST_BOT) ? MP_TOP :
                            (ODD_SIZE ? MP_DROP : MP_IDLE);
      default: wrap_state = MP_IDLE;
    endcase
  end

  pool_line_buf #(
    .N     (N),
    .DEPTH (OUT_SIZE),
    .AW    (AW)
  ) u_lbuf (
    .clk    (clk),
    .wr_en  (lbuf_we),
    .wr_idx (col_half[AW-1:0]),
    .wr_dat (top_max),
    .rd_idx (col_half[AW-1:0]),
    .rd_dat (lbuf_rd)
  );

  // Raster position, row-type FSM, horizontal pair register and pooled output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= MP_IDLE;
      col           <= '0;
      row           <= '0;
      h             <= '0;
      pool_dout     <= '0;
      pool_dout_vld <= 1'b0;
      pool_dout_end <= 1'b0;
    end else if (clr) begin
      state         <= MP_IDLE;
      col           <= '0;
      row           <= '0;
      pool_dout_vld <= 1'b0;
      pool_dout_end <= 1'b0;
    end else begin
      pool_dout_vld <= 1'b0;
      pool_dout_end <= 1'b0;
      if (accept) begin
        if (col_last) begin
          col   <= '0;
          row   <= row_last ? '0 : row + CW'(1);
          state <= wrap_state;
        end else begin
          col   <= col + CW'(1);
          state <= cur;
        end
        if (!col[0] && col_used) h <= din;
        if ((cur == MP_BOT) && col[0] && col_used) begin
          pool_dout     <= win_max;
          pool_dout_vld <= 1'b1;
        end
        if (col_last && row_last) pool_dout_end <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_unit.sv
// Scoreboard bench for maxpool_unit: one 4x4 and one 5x5 instance.
// Expected pixels come from a frame-array model of 2x2 window maxima.
// A negedge monitor matches every valid/end pulse against the queue.
module tb_maxpool_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr4 = 1'b0, vld4 = 1'b0;
  logic       clr5 = 1'b0, vld5 = 1'b0;
  logic [7:0] din4 = '0, din5 = '0;
  logic [7:0] dout4, dout5;
  logic       dv4, de4, dv5, de5;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {
    int         d;
    int         stamp;
    bit         is_end;
    logic [7:0] val;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] img[2][5][5];
  int         pos[2];
  logic [7:0] last_out[2];

  maxpool_unit #(.N(8), .IN_SIZE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr4), .din_vld(vld4), .din(din4),
    .pool_dout(dout4), .pool_dout_vld(dv4), .pool_dout_end(de4)
  );

  maxpool_unit #(.N(8), .IN_SIZE(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .clr(clr5), .din_vld(vld5), .din(din5),
    .pool_dout(dout5), .pool_dout_vld(dv5), .pool_dout_end(de5)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // Reference: record the pixel; a window completes at its bottom-right pixel.
  task automatic model(input int d, input logic [7:0] v, input int stamp);
    int   sz, os, r, c;
    exp_t e;
    sz = (d == 0) ? 4 : 5;
    os = sz / 2;
    r  = pos[d] / sz;
    c  = pos[d] % sz;
    img[d][r][c] = v;
    if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * os) && (c < 2 * os)) begin
      e.d = d; e.stamp = stamp; e.is_end = 1'b0;
      e.val = mx(mx(img[d][r-1][c-1], img[d][r-1][c]), mx(img[d][r][c-1], img[d][r][c]));
      last_out[d] = e.val;
      expq.push_back(e);
    end
    if (pos[d] == sz * sz - 1) begin
      e.d = d; e.stamp = stamp; e.is_end = 1'b1; e.val = '0;
      expq.push_back(e);
    end
    pos[d] = (pos[d] + 1) % (sz * sz);
  endtask

  // Called at #1 after a rising edge; returns at #1 after a rising edge.
  task automatic drive(input int d, input logic [7:0] v, input int gap);
    if (d == 0) begin vld4 = 1'b1; din4 = v; end
    else        begin vld5 = 1'b1; din5 = v; end
    model(d, v, cyc + 1);
    @(posedge clk); #1;
    if (d == 0) vld4 = 1'b0; else vld5 = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Abort with a live beat in the same cycle; the beat must be discarded.
  task automatic abort4(input logic [7:0] v);
    clr4 = 1'b1; vld4 = 1'b1; din4 = v;
    @(posedge clk); #1;
    clr4 = 1'b0; vld4 = 1'b0;
    pos[0] = 0;
  endtask

  task automatic score(input int d, input bit fire, input bit is_end, input logic [7:0] val);
    int idx;
    if (!fire) return;
    idx = -1;
    foreach (expq[i]) if (idx < 0 && expq[i].d == d && expq[i].is_end == is_end) idx = i;
    if (idx < 0) begin
      chk(is_end ? "spurious_end" : "spurious_vld", d, -1);
    end else begin
      chk(is_end ? "end_cycle" : "vld_cycle", cyc, expq[idx].stamp);
      if (!is_end) chk("pool_dout", int'(val), int'(expq[idx].val));
      expq.delete(idx);
    end
  endtask

  // Monitor: match pulses, then flag anything whose time has passed unseen.
  always @(negedge clk) begin
    if (rst_n) begin
      score(0, dv4, 1'b0, dout4);
      score(0, de4, 1'b1, dout4);
      score(1, dv5, 1'b0, dout5);
      score(1, de5, 1'b1, dout5);
      while (expq.size() > 0 && expq[0].stamp < cyc) begin
        chk(expq[0].is_end ? "missed_end" : "missed_vld", expq[0].stamp, -1);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    pos[0] = 0; pos[1] = 0;
    last_out[0] = '0; last_out[1] = '0;
    #12;
    chk("rst_dout4", int'(dout4), 0);
    chk("rst_vld4", int'(dv4), 0);
    chk("rst_end4", int'(de4), 0);
    chk("rst_dout5", int'(dout5), 0);
    chk("rst_vld5", int'(dv5), 0);
    chk("rst_end5", int'(de5), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Contiguous 1..16, then same frame with 3-cycle gaps.
    for (int i = 1; i <= 16; i++) drive(0, 8'(i), 0);
    for (int i = 1; i <= 16; i++) drive(0, 8'(i), 3);

    // Two frames back to back with no bubble.
    for (int i = 1; i <= 16; i++) drive(0, 8'(i), 0);
    for (int i = 1; i <= 16; i++) drive(0, 8'd255, 0);

    // Abort after beat 7 with beat 8 colliding, then a descending frame.
    for (int i = 1; i <= 7; i++) drive(0, 8'(i), 0);
    abort4(8'd8);
    for (int i = 16; i >= 1; i--) drive(0, 8'(i), 0);
    repeat (2) begin @(posedge clk); #1; end

    // Asynchronous reset in the middle of a cycle after beat 10.
    for (int i = 1; i <= 10; i++) drive(0, 8'(i), 0);
    chk("hold_dout4", int'(dout4), int'(last_out[0]));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout4", int'(dout4), 0);
    chk("arst_vld4", int'(dv4), 0);
    chk("arst_end4", int'(de4), 0);
    pos[0] = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 16; i++) drive(0, 8'(i), 0);

    // Odd size: trailing column and row ignored, separate end pulse.
    for (int i = 1; i <= 25; i++) drive(1, 8'(i), 0);
    repeat (2) begin @(posedge clk); #1; end

    // Random frames on both instances concurrently, small range for ties.
    fork
      begin
        for (int i = 0; i < 48; i++)
          drive(0, 8'($urandom_range(0, 15) * (($urandom_range(0, 3) == 0) ? 17 : 1)),
                int'($urandom_range(0, 2)));
      end
      begin
        for (int i = 0; i < 75; i++)
          drive(1, 8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
      end
    join

    repeat (4) begin @(posedge clk); #1; end
    chk("drain", expq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
